// File: rtl/frame_slot_mgr_pkg.sv
// frame_slot_mgr_pkg: shared slot/allocator encodings and sequence width for the frame slot manager
package frame_slot_mgr_pkg;
  localparam int SEQ_W = 16;
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_READY   = 2'd2,
    SLOT_READING = 2'd3
  } slot_st_e;
  typedef enum logic [1:0] {
    ALLOC_IDLE = 2'd0,
    ALLOC_WR   = 2'd1,
    ALLOC_RD   = 2'd2
  } alloc_e;
endpackage

// File: rtl/frame_slot_mgr_age_select.sv
// frame_slot_mgr_age_select: picks the oldest and newest slot among a mask using wrap-safe seq compare
//   mask_i  : slots eligible for selection
//   seq_i   : per-slot sequence tags
//   old_o   : index of the oldest eligible slot
//   new_o   : index of the newest eligible slot
//   valid_o : at least one slot eligible
module frame_slot_mgr_age_select
  import frame_slot_mgr_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]     mask_i,
  input  logic [SEQ_W-1:0] seq_i [N],
  output logic [IW-1:0]    old_o,
  output logic [IW-1:0]    new_o,
  output logic             valid_o
);
  // Sign of the 16-bit difference orders tags correctly across the wrap.
  always_comb begin
    old_o   = '0;
    new_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i]) begin
        if (!valid_o || $signed(seq_i[i] - seq_i[old_o]) < 0) old_o = IW'(i);
        if (!valid_o || $signed(seq_i[i] - seq_i[new_o]) > 0) new_o = IW'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_slot_mgr.sv
// frame_slot_mgr: ring of DDR frame slots shared by an image writer and a host reader
//   clk_i, reset_clk_n_i           : clock, asynchronous active-low reset
//   wr_req_i/wr_done_i/wr_abort_i  : writer slot request, frame complete, frame discarded
//   wr_grant_o, wr_addr_o          : grant pulse and base address of the granted slot
//   wr_busy_o                      : a slot is being written
//   rd_req_i, readout_done_i       : host frame request, readout finished/cancelled
//   readout_start_o/addr_o/count_o : readout command to the DDR reader
//   rd_busy_o, rd_avail_o          : a slot is being read, a completed frame is waiting
//   rd_frame_seq_o, drop_count_o   : sequence of the frame handed out, saturating drop count
module frame_slot_mgr
  import frame_slot_mgr_pkg::*;
#(
  parameter int               NUM_SLOTS   = 4,
  parameter logic [29:0]      SLOT_BASE   = 30'h0000_0000,
  parameter logic [29:0]      SLOT_STRIDE = 30'h0100_0000,
  parameter logic [23:0]      FRAME_BYTES = 24'h4C_E300,
  parameter bit               READ_LATEST = 1'b1,
  // Reset value of the sequence counter; nonzero only to exercise the wrap.
  parameter logic [SEQ_W-1:0] SEQ_INIT    = '0
) (
  input  logic             clk_i,
  input  logic             reset_clk_n_i,
  input  logic             wr_req_i,
  input  logic             wr_done_i,
  input  logic             wr_abort_i,
  output logic             wr_grant_o,
  output logic [29:0]      wr_addr_o,
  output logic             wr_busy_o,
  input  logic             rd_req_i,
  input  logic             readout_done_i,
  output logic             readout_start_o,
  output logic [29:0]      readout_addr_o,
  output logic [23:0]      readout_count_o,
  output logic             rd_busy_o,
  output logic             rd_avail_o,
  output logic [SEQ_W-1:0] rd_frame_seq_o,
  output logic [SEQ_W-1:0] drop_count_o
);
  localparam int IW = $clog2(NUM_SLOTS);
  slot_st_e             st_q [NUM_SLOTS];
  slot_st_e             st_d [NUM_SLOTS];
  logic [SEQ_W-1:0]     tag_q [NUM_SLOTS];
  logic [SEQ_W-1:0]     tag_d [NUM_SLOTS];
  logic [SEQ_W-1:0]     seq_q, seq_d, rd_seq_q, rd_seq_d, drop_q, drop_d;
  alloc_e               alloc_q, alloc_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [29:0]          wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [23:0]          rd_cnt_q, rd_cnt_d;
  logic [NUM_SLOTS-1:0] free_m, ready_m, writing_m, reading_m;
  logic [IW-1:0]        free_idx, old_idx, new_idx, w_idx, r_idx;
  logic                 any_free, any_ready, rd_want, drop_inc;

  function automatic logic [29:0] slot_addr(input logic [IW-1:0] idx);
    return SLOT_BASE + 30'(idx) * SLOT_STRIDE;
  endfunction

  // A slot being written counts as free for a new request unless it completes this cycle,
  // so a re-request abandons the current frame and may reuse the same slot.
  always_comb begin
    free_m    = '0;
    ready_m   = '0;
    writing_m = '0;
    reading_m = '0;
    free_idx  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      writing_m[i] = st_q[i] == SLOT_WRITING;
      ready_m[i]   = st_q[i] == SLOT_READY;
      reading_m[i] = st_q[i] == SLOT_READING;
      free_m[i]    = st_q[i] == SLOT_FREE || (writing_m[i] && !wr_done_i);
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) if (free_m[i]) free_idx = IW'(i);
    any_free = |free_m;
  end

  frame_slot_mgr_age_select #(.N(NUM_SLOTS), .IW(IW)) u_age (
    .mask_i  (ready_m),
    .seq_i   (tag_q),
    .old_o   (old_idx),
    .new_o   (new_idx),
    .valid_o (any_ready)
  );

  // Allocation decisions use the current slot states only; completions and frees this
  // cycle become visible to the allocator on the next cycle.
  always_comb begin
    st_d      = st_q;
    tag_d     = tag_q;
    seq_d     = seq_q;
    rd_seq_d  = rd_seq_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    alloc_d   = ALLOC_IDLE;
    w_idx     = any_free ? free_idx : old_idx;
    r_idx     = READ_LATEST ? new_idx : old_idx;
    rd_want   = rd_pend_q || (rd_req_i && !(|reading_m));
    drop_inc  = (|writing_m && !wr_done_i && (wr_abort_i || wr_req_i)) || (wr_req_i && !any_free);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (writing_m[i] && (wr_done_i || wr_abort_i || wr_req_i)) st_d[i] = wr_done_i ? SLOT_READY : SLOT_FREE;
      if (reading_m[i] && readout_done_i) st_d[i] = SLOT_FREE;
    end
    if (wr_req_i) begin
      alloc_d      = ALLOC_WR;
      st_d[w_idx]  = SLOT_WRITING;
      tag_d[w_idx] = seq_q;
      seq_d        = seq_q + 1'b1;
      wr_addr_d    = slot_addr(w_idx);
    end else if (rd_want && any_ready) begin
      alloc_d      = ALLOC_RD;
      st_d[r_idx]  = SLOT_READING;
      rd_seq_d     = tag_q[r_idx];
      rd_addr_d    = slot_addr(r_idx);
      rd_cnt_d     = FRAME_BYTES;
    end
    rd_pend_d = rd_want && alloc_d != ALLOC_RD;
    drop_d    = drop_q + SEQ_W'(drop_inc && drop_q != '1);
  end

  always_ff @(posedge clk_i or negedge reset_clk_n_i) begin
    if (!reset_clk_n_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]  <= SLOT_FREE;
        tag_q[i] <= '0;
      end
      seq_q     <= SEQ_INIT;
      rd_seq_q  <= '0;
      drop_q    <= '0;
      alloc_q   <= ALLOC_IDLE;
      rd_pend_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      st_q      <= st_d;
      tag_q     <= tag_d;
      seq_q     <= seq_d;
      rd_seq_q  <= rd_seq_d;
      drop_q    <= drop_d;
      alloc_q   <= alloc_d;
      rd_pend_q <= rd_pend_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign wr_grant_o      = alloc_q == ALLOC_WR;
  assign readout_start_o = alloc_q == ALLOC_RD;
  assign wr_addr_o       = wr_addr_q;
  assign wr_busy_o       = |writing_m;
  assign readout_addr_o  = rd_addr_q;
  assign readout_count_o = rd_cnt_q;
  assign rd_busy_o       = |reading_m;
  assign rd_avail_o      = any_ready;
  assign rd_frame_seq_o  = rd_seq_q;
  assign drop_count_o    = drop_q;
endmodule

// File: tb/tb_frame_slot_mgr.sv
// tb_frame_slot_mgr: directed checks of frame_slot_mgr (newest-first and oldest-first instances)
module tb_frame_slot_mgr;
  localparam logic [29:0] STR = 30'h0100_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_req = 1'b0, wr_done = 1'b0, wr_abort = 1'b0, rd_req = 1'b0, readout_done = 1'b0;
  logic        a_grant, a_wbusy, a_start, a_rbusy, a_avail;
  logic [29:0] a_waddr, a_raddr;
  logic [23:0] a_cnt;
  logic [15:0] a_seq, a_drop;
  logic        b_grant, b_wbusy, b_start, b_rbusy, b_avail;
  logic [29:0] b_waddr, b_raddr;
  logic [23:0] b_cnt;
  logic [15:0] b_seq, b_drop;
  int errs = 0, checks = 0;

  frame_slot_mgr #(.READ_LATEST(1'b1)) u_lat (
    .clk_i(clk), .reset_clk_n_i(rst_n), .wr_req_i(wr_req), .wr_done_i(wr_done), .wr_abort_i(wr_abort),
    .wr_grant_o(a_grant), .wr_addr_o(a_waddr), .wr_busy_o(a_wbusy), .rd_req_i(rd_req),
    .readout_done_i(readout_done), .readout_start_o(a_start), .readout_addr_o(a_raddr),
    .readout_count_o(a_cnt), .rd_busy_o(a_rbusy), .rd_avail_o(a_avail), .rd_frame_seq_o(a_seq),
    .drop_count_o(a_drop)
  );

  frame_slot_mgr #(.READ_LATEST(1'b0), .SEQ_INIT(16'hFFFE)) u_old (
    .clk_i(clk), .reset_clk_n_i(rst_n), .wr_req_i(wr_req), .wr_done_i(wr_done), .wr_abort_i(wr_abort),
    .wr_grant_o(b_grant), .wr_addr_o(b_waddr), .wr_busy_o(b_wbusy), .rd_req_i(rd_req),
    .readout_done_i(readout_done), .readout_start_o(b_start), .readout_addr_o(b_raddr),
    .readout_count_o(b_cnt), .rd_busy_o(b_rbusy), .rd_avail_o(b_avail), .rd_frame_seq_o(b_seq),
    .drop_count_o(b_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic w, input logic d, input logic a, input logic r, input logic o);
    wr_req = w; wr_done = d; wr_abort = a; rd_req = r; readout_done = o;
    step();
    {wr_req, wr_done, wr_abort, rd_req, readout_done} = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [29:0] lap [6];
    lap = '{2*STR, 3*STR, 0, 2*STR, 3*STR, 0};
    do_reset();
    chk("rst_grant", a_grant, 0);
    chk("rst_waddr", a_waddr, 0);
    chk("rst_start", a_start, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_avail", a_avail, 0);
    chk("rst_drop", a_drop, 0);
    // basic write, read, free
    pulse(1, 0, 0, 0, 0);
    chk("t1_grant", a_grant, 1);
    chk("t1_waddr", a_waddr, 0);
    chk("t1_wbusy", a_wbusy, 1);
    pulse(0, 1, 0, 0, 0);
    chk("t1_avail", a_avail, 1);
    chk("t1_wbusy_off", a_wbusy, 0);
    pulse(0, 0, 0, 1, 0);
    chk("t1_start", a_start, 1);
    chk("t1_raddr", a_raddr, 0);
    chk("t1_count", a_cnt, 24'h4C_E300);
    chk("t1_rbusy", a_rbusy, 1);
    pulse(0, 0, 0, 0, 1);
    chk("t1_rbusy_off", a_rbusy, 0);
    chk("t1_avail_off", a_avail, 0);
    pulse(1, 0, 0, 0, 0);
    chk("t1_slot0_free", a_waddr, 0);
    // five frames into four slots, newest read back
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pulse(1, 0, 0, 0, 0);
      chk($sformatf("t2_waddr%0d", k), a_waddr, (k == 4) ? 30'h0 : 30'(k) * STR);
      pulse(0, 1, 0, 0, 0);
    end
    chk("t2_drop", a_drop, 1);
    pulse(0, 0, 0, 1, 0);
    chk("t2_start", a_start, 1);
    chk("t2_seq", a_seq, 4);
    chk("t2_raddr", a_raddr, 0);
    // slot 1 held by reader while writer laps
    do_reset();
    pulse(1, 0, 0, 0, 0); pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0); pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    chk("t3_raddr", a_raddr, STR);
    for (int k = 0; k < 6; k++) begin
      pulse(1, 0, 0, 0, 0);
      chk($sformatf("t3_lap%0d", k), a_waddr, lap[k]);
      pulse(0, 1, 0, 0, 0);
    end
    chk("t3_raddr_hold", a_raddr, STR);
    chk("t3_drop", a_drop, 4);
    // simultaneous write and read requests
    do_reset();
    pulse(1, 0, 0, 0, 0); pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 1, 0);
    chk("t4_grant", a_grant, 1);
    chk("t4_waddr", a_waddr, STR);
    chk("t4_nostart", a_start, 0);
    step();
    chk("t4_start", a_start, 1);
    chk("t4_nogrant", a_grant, 0);
    chk("t4_raddr", a_raddr, 0);
    // read request waiting for a completed frame
    do_reset();
    pulse(0, 0, 0, 1, 0);
    chk("t5_nostart0", a_start, 0);
    pulse(1, 0, 0, 0, 0);
    chk("t5_grant", a_grant, 1);
    repeat (8) step();
    chk("t5_nostart1", a_start, 0);
    pulse(0, 1, 0, 0, 0);
    chk("t5_nostart2", a_start, 0);
    chk("t5_avail", a_avail, 1);
    step();
    chk("t5_start", a_start, 1);
    chk("t5_raddr", a_raddr, 0);
    // oldest-first across the sequence wrap, then reset mid-read
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse(1, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 0);
    end
    pulse(0, 0, 0, 1, 0);
    chk("t6_seq0", b_seq, 16'hFFFE);
    chk("t6_raddr0", b_raddr, 0);
    pulse(0, 0, 0, 0, 1);
    pulse(0, 0, 0, 1, 0);
    chk("t6_start", b_start, 1);
    chk("t6_seq1", b_seq, 16'hFFFF);
    chk("t6_raddr1", b_raddr, STR);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_raddr", b_raddr, 0);
    chk("t6_rst_seq", b_seq, 0);
    chk("t6_rst_count", b_cnt, 0);
    chk("t6_rst_avail", b_avail, 0);
    chk("t6_rst_rbusy", b_rbusy, 0);
    chk("t6_rst_waddr", b_waddr, 0);
    // abort and re-request while writing
    do_reset();
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    chk("t7_abort_drop", a_drop, 1);
    chk("t7_abort_wbusy", a_wbusy, 0);
    chk("t7_abort_avail", a_avail, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk("t7_rereq_addr", a_waddr, 0);
    chk("t7_rereq_drop", a_drop, 2);
    chk("t7_rereq_wbusy", a_wbusy, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
